// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM
// for the single-issue RV32I core; gates decoder write enables into one commit
// per instruction and owns PC-update / IR-capture timing.
//
// Ports:
//   clock, reset_n        core clock, asynchronous active-low reset
//   start, halt_req       leave IDLE/HALT; stop after current instruction retires
//   imem_req/imem_ready   instruction fetch handshake
//   dmem_req/dmem_ready   data access handshake
//   dec_*                 level-valued decoder flags for the current instruction
//   ir_load, pc_load      one-cycle strobes per instruction
//   pc_sel_target         0: PC+4, 1: decoder target (qualified by pc_load)
//   rf_wEn, mem_wEn       gated register-file / data-memory writes
//   state, busy, error    FSM status; error is sticky until reset
//   cycle_count,
//   instret_count         performance counters
//
// Optional feature: define PERF_CNT_EN to build the performance counters;
// otherwise both counter ports are tied to zero and no counter flops exist.
module core_sequencer #(
    parameter int ADDRESS_BITS = 16,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_BITS     = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                halt_req,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                dmem_req,
    input  logic                dmem_ready,
    input  logic                dec_wEn,
    input  logic                dec_mem_wEn,
    input  logic                dec_wb_sel,
    input  logic                dec_next_PC_sel,
    output logic                ir_load,
    output logic                pc_load,
    output logic                pc_sel_target,
    output logic                rf_wEn,
    output logic                mem_wEn,
    output logic [2:0]          state,
    output logic                busy,
    output logic                error,
    output logic [CNT_BITS-1:0] cycle_count,
    output logic [CNT_BITS-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    // Watchdog counter is just wide enough to hold MEM_TIMEOUT.
    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIMIT = TW'(MEM_TIMEOUT);
    localparam bit WDOG_EN = (MEM_TIMEOUT > 0);

    // PC width is owned by the datapath; kept here for top-level consistency.
    logic [ADDRESS_BITS-1:0] unused_pc_width;
    assign unused_pc_width = '0;

    state_t        state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [TW-1:0] wait_inc;
    logic          wait_expired;

    assign wait_inc     = wait_q + 1'b1;
    assign wait_expired = WDOG_EN && (wait_inc == TLIMIT);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                // Ready in the same cycle the limit is reached still wins.
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end else if (WDOG_EN) begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                wait_d = '0;
                if (dec_mem_wEn || dec_wb_sel) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end else if (WDOG_EN) begin
                    wait_d = wait_inc;
                end
            end
            S_WRITEBACK: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // All outputs decode the live state so an async reset drops them at once.
    logic in_fetch, in_mem, in_wb;
    assign in_fetch = (state_q == S_FETCH);
    assign in_mem   = (state_q == S_MEMORY);
    assign in_wb    = (state_q == S_WRITEBACK);

    assign imem_req      = in_fetch;
    assign ir_load       = in_fetch && imem_ready;
    assign dmem_req      = in_mem;
    assign mem_wEn       = in_mem && dec_mem_wEn;
    assign rf_wEn        = in_wb && dec_wEn;
    assign pc_load       = in_wb;
    assign pc_sel_target = in_wb && dec_next_PC_sel;
    assign state         = state_q;
    assign busy          = (state_q >= S_FETCH) && (state_q <= S_WRITEBACK);
    assign error         = (state_q == S_ERROR);

`ifdef PERF_CNT_EN
    logic [CNT_BITS-1:0] cyc_q, cyc_d;
    logic [CNT_BITS-1:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (busy) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (in_wb) begin
            ret_d = ret_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed self-checking bench for core_sequencer.
// Inputs change #1 after posedge; outputs are sampled on the negedge.
module tb_core_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic        dmem_req;
    logic        dmem_ready = 1'b0;
    logic        dec_wEn = 1'b0;
    logic        dec_mem_wEn = 1'b0;
    logic        dec_wb_sel = 1'b0;
    logic        dec_next_PC_sel = 1'b0;
    logic        ir_load;
    logic        pc_load;
    logic        pc_sel_target;
    logic        rf_wEn;
    logic        mem_wEn;
    logic [2:0]  state;
    logic        busy;
    logic        error;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    int n_cmp = 0;
    int n_bad = 0;

    core_sequencer #(
        .ADDRESS_BITS(16),
        .MEM_TIMEOUT (15),
        .CNT_BITS    (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .halt_req       (halt_req),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .dec_wEn        (dec_wEn),
        .dec_mem_wEn    (dec_mem_wEn),
        .dec_wb_sel     (dec_wb_sel),
        .dec_next_PC_sel(dec_next_PC_sel),
        .ir_load        (ir_load),
        .pc_load        (pc_load),
        .pc_sel_target  (pc_sel_target),
        .rf_wEn         (rf_wEn),
        .mem_wEn        (mem_wEn),
        .state          (state),
        .busy           (busy),
        .error          (error),
        .cycle_count    (cycle_count),
        .instret_count  (instret_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample;
        @(negedge clock);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_state", state, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {imem_req, dmem_req, ir_load, pc_load,
                           rf_wEn, mem_wEn, error}, 7'd0);
        check("rst_cyc", cycle_count, 0);
        check("rst_ret", instret_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // T1: ADD, zero-wait fetch
        start = 1'b1;
        dec_wEn = 1'b1;
        imem_ready = 1'b1;
        sample();
        check("t1_idle", state, 3'd0);
        check("t1_idle_ir", ir_load, 1'b0);
        step();
        start = 1'b0;
        sample();
        check("t1_fetch", state, 3'd1);
        check("t1_ir_load", ir_load, 1'b1);
        check("t1_imem_req", imem_req, 1'b1);
        step();
        imem_ready = 1'b0;
        sample();
        check("t1_decode", state, 3'd2);
        check("t1_dec_ir", ir_load, 1'b0);
        check("t1_dec_rf", rf_wEn, 1'b0);
        step();
        sample();
        check("t1_exec", state, 3'd3);
        check("t1_exec_pc", pc_load, 1'b0);
        step();
        sample();
        check("t1_wb", state, 3'd5);
        check("t1_wb_rf", rf_wEn, 1'b1);
        check("t1_wb_pc", pc_load, 1'b1);
        check("t1_wb_sel", pc_sel_target, 1'b0);
        check("t1_wb_mem", mem_wEn, 1'b0);
        step();
        sample();
        check("t1_refetch", state, 3'd1);
        check("t1_refetch_rf", rf_wEn, 1'b0);
        check("t1_refetch_pc", pc_load, 1'b0);

        // T2: store, dmem_ready on the 4th MEMORY cycle
        dec_wEn = 1'b0;
        dec_mem_wEn = 1'b1;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        sample();
        check("t2_exec", state, 3'd3);
        check("t2_exec_mem", mem_wEn, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            sample();
            check($sformatf("t2_mem_st%0d", i), state, 3'd4);
            check($sformatf("t2_mem_we%0d", i), {mem_wEn, dmem_req}, 2'b11);
            check($sformatf("t2_mem_rf%0d", i), rf_wEn, 1'b0);
            step();
        end
        dmem_ready = 1'b0;
        sample();
        check("t2_wb", state, 3'd5);
        check("t2_wb_we", {mem_wEn, rf_wEn, pc_load}, 3'b001);
        step();

        // T3: taken branch
        dec_mem_wEn = 1'b0;
        dec_next_PC_sel = 1'b1;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        sample();
        check("t3_wb", state, 3'd5);
        check("t3_wb_outs", {pc_load, pc_sel_target, rf_wEn}, 3'b110);
        step();
        dec_next_PC_sel = 1'b0;

        // T4a: fetch timeout after 15 cycles
        for (int i = 0; i < 15; i++) begin
            sample();
            if (i == 0 || i == 14)
                check($sformatf("t4_wait%0d", i), state, 3'd1);
            step();
        end
        sample();
        check("t4_error_state", state, 3'd7);
        check("t4_error", error, 1'b1);
        check("t4_err_outs", {imem_req, dmem_req, pc_load, busy}, 4'd0);
        start = 1'b1;
        step();
        sample();
        check("t4_start_ignored", state, 3'd7);
        start = 1'b0;
        reset_n = 1'b0;
        #2;
        check("t4_reset_clears", {state, error}, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // T4b: ready on the 15th fetch cycle wins
        start = 1'b1;
        dec_wEn = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        imem_ready = 1'b1;
        sample();
        check("t4_15th_fetch", state, 3'd1);
        check("t4_15th_ir", ir_load, 1'b1);
        step();
        imem_ready = 1'b0;
        sample();
        check("t4_ready_wins", {state, error}, {3'd2, 1'b0});
        step();
        step();

        // T5a: halt_req in WRITEBACK
        halt_req = 1'b1;
        sample();
        check("t5_wb", state, 3'd5);
        step();
        halt_req = 1'b0;
        sample();
        check("t5_halt", state, 3'd6);
        check("t5_halt_busy", busy, 1'b0);
        step();
        sample();
        check("t5_halt_hold", state, 3'd6);
        start = 1'b1;
        step();
        start = 1'b0;
        sample();
        check("t5_restart", state, 3'd1);

        // T5b: reset during a store's MEMORY phase
        dec_wEn = 1'b0;
        dec_mem_wEn = 1'b1;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        sample();
        check("t5_mem", {state, mem_wEn}, {3'd4, 1'b1});
        #1;
        reset_n = 1'b0;
        #2;
        check("t5_rst_state", state, 3'd0);
        check("t5_rst_outs", {mem_wEn, dmem_req, rf_wEn, pc_load}, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        dec_mem_wEn = 1'b0;
        step();

        // T6: 10 zero-wait ADDs then halt
        dec_wEn = 1'b1;
        imem_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            step();
            step();
            halt_req = (n == 9);
            step();
        end
        halt_req = 1'b0;
        imem_ready = 1'b0;
        sample();
        check("t6_halt", state, 3'd6);
`ifdef PERF_CNT_EN
        check("t6_instret", instret_count, 10);
        check("t6_cycles", cycle_count, 40);
`else
        check("t6_instret", instret_count, 0);
        check("t6_cycles", cycle_count, 0);
`endif
        step();
        sample();
`ifdef PERF_CNT_EN
        check("t6_cyc_hold", cycle_count, 40);
`else
        check("t6_cyc_hold", cycle_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
